layer_feed_controller: RTL and testbench

Sequencer that drives the neural layer's input side. It buffers the M×P weighted-sum results written by the matrix multiplier core, then streams them one at a time into the layer using the layer's start / matrix_valid protocol. It collects each activated `app_result` into an output buffer that the host reads back, and flags completion or a responder timeout.

---
 rtl/layer_feed_controller.sv | 94 +++++++++
 tb/tb_layer_feed_controller.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_feed_controller.sv
// layer_feed_controller: buffers core results and streams them one by one through the neural layer, collecting activated outputs
module layer_feed_controller #(
    parameter int M          = 3,
    parameter int P          = 3,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 64,
    localparam int E  = M * P,
    localparam int AW = (E > 1) ? $clog2(E) : 1,
    localparam int RW = 2 * DATA_WIDTH,
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    input  logic          core_wen,
    input  logic [AW-1:0] core_addr,
    input  logic [RW-1:0] core_result,
    output logic          layer_start,
    output logic [RW-1:0] matrix_result,
    output logic          matrix_valid,
    input  logic [RW-1:0] app_result,
    input  logic          app_valid,
    input  logic          app_done,
    input  logic [AW-1:0] rd_addr,
    output logic [RW-1:0] rd_data,
    output logic          busy,
    output logic          done,
    output logic          error
);
    typedef enum logic [2:0] {IDLE, ISSUE, PRESENT, WAIT, FINISH} state_t;
    state_t        state, state_d;
    logic [AW-1:0] k;
    logic [TW-1:0] w;
    logic          last_k, w_last;
    logic [RW-1:0] in_mem  [E];
    logic [RW-1:0] out_mem [E];
    logic          unused_ok;
    assign unused_ok    = app_done;
    assign last_k       = k == AW'(E - 1);
    assign w_last       = w == TW'(TIMEOUT - 1);
    assign layer_start  = state == ISSUE;
    assign matrix_valid = state == PRESENT;
    assign done         = state == FINISH;
    assign busy         = state != IDLE;
    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end
    // next-state: a response in WAIT wins over the timeout on the same cycle
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = run ? ISSUE : IDLE;
            ISSUE:   state_d = PRESENT;
            PRESENT: state_d = WAIT;
            WAIT:    state_d = app_valid ? (last_k ? FINISH : ISSUE) : (w_last ? FINISH : WAIT);
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // element/wait counters, presented element, sticky error and registered read port
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k             <= '0;
            w             <= '0;
            error         <= 1'b0;
            matrix_result <= '0;
            rd_data       <= '0;
        end else begin
            rd_data <= out_mem[rd_addr];
            case (state)
                IDLE: if (run) begin
                    k     <= '0;
                    error <= 1'b0;
                end
                ISSUE:   matrix_result <= in_mem[k];
                PRESENT: w <= '0;
                WAIT: begin
                    if (app_valid) begin
                        if (!last_k) k <= k + AW'(1);
                    end else if (w_last) error <= 1'b1;
                    else w <= w + TW'(1);
                end
                default: ;
            endcase
        end
    end
    // buffers keep their contents through reset; captures are suppressed on a reset edge
    always_ff @(posedge clk) begin
        if (core_wen && !busy) in_mem[core_addr] <= core_result;
        if (rst_n && state == WAIT && app_valid) out_mem[k] <= app_result;
    end
endmodule

// File: tb/tb_layer_feed_controller.sv
// tb_layer_feed_controller: scenario tasks with a behavioural ReLU layer and an out_mem readback scoreboard
module tb_layer_feed_controller;
    localparam int E = 9;
    logic        clk = 1'b0, rst_n = 1'b0, run = 1'b0, core_wen = 1'b0;
    logic [3:0]  core_addr = '0, rd_addr = '0;
    logic [15:0] core_result = '0, app_result = '0;
    logic        app_valid = 1'b0, app_done = 1'b0;
    logic        layer_start, matrix_valid, busy, done, error;
    logic [15:0] matrix_result, rd_data;
    int errors = 0, checks = 0;
    int ls_cnt = 0, mv_cnt = 0, hold_bad = 0, val_bad = 0, idx = 0, pend = 0;
    int lat = 4;
    logic        holding = 1'b0, prev_busy = 1'b0, no_resp = 1'b0, force_av = 1'b0;
    logic [15:0] hold_val = '0, pend_val = '0, force_res = '0;
    logic [15:0] exp_in  [E];
    logic [15:0] exp_out [E];
    logic [15:0] exp_q   [$];
    logic [15:0] vec_a [E] = '{16'h0005, 16'hFFFD, 16'h0000, 16'h0064, 16'hFFFF, 16'h0007, 16'h7FFF, 16'h8000, 16'h0002};
    logic [15:0] res_a [E] = '{16'd5, 16'd0, 16'd0, 16'd100, 16'd0, 16'd7, 16'd32767, 16'd0, 16'd2};
    logic [15:0] vec_b [E] = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 16'd70, 16'd80, 16'd90};

    layer_feed_controller #(.M(3), .P(3), .DATA_WIDTH(8), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .core_wen(core_wen), .core_addr(core_addr),
        .core_result(core_result), .layer_start(layer_start), .matrix_result(matrix_result),
        .matrix_valid(matrix_valid), .app_result(app_result), .app_valid(app_valid),
        .app_done(app_done), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] relu(input logic [15:0] x);
        return x[15] ? 16'd0 : x;
    endfunction

    // layer model plus monitors for pulse counts, presented values and hold stability
    always @(negedge clk) begin
        if (busy !== 1'b1) holding = 1'b0;
        if (busy === 1'b1 && prev_busy !== 1'b1) idx = 0;
        prev_busy = busy;
        if (holding && matrix_result !== hold_val) hold_bad++;
        if (layer_start === 1'b1) ls_cnt++;
        if (matrix_valid === 1'b1) begin
            if (idx >= E) val_bad++;
            else if (matrix_result !== exp_in[idx]) val_bad++;
            hold_val = matrix_result;
            holding  = 1'b1;
            idx++;
            mv_cnt++;
        end
        app_valid  = force_av;
        app_result = force_res;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                app_valid  = 1'b1;
                app_result = pend_val;
                holding    = 1'b0;
            end
        end
        if (matrix_valid === 1'b1 && !no_resp) begin
            pend     = lat;
            pend_val = relu(matrix_result);
        end
    end

    task automatic load(input int sel);
        for (int i = 0; i < E; i++) begin
            @(negedge clk);
            core_wen    = 1'b1;
            core_addr   = 4'(i);
            core_result = sel ? vec_b[i] : vec_a[i];
            exp_in[i]   = core_result;
        end
        @(negedge clk);
        core_wen = 1'b0;
    endtask

    task automatic readback(input int n);
        logic [15:0] e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rd_addr = 4'(i);
            @(negedge clk);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL readback[%0d]: got %0h, scoreboard empty", i, rd_data);
            end else begin
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    errors++;
                    $display("FAIL readback[%0d]: got %0h expected %0h", i, rd_data, e);
                end
            end
        end
    endtask

    task automatic do_run(input int budget, input int mode, output int dn, output logic er,
                          output logic e0, output int busy_lo);
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        dn = -1;
        er = 1'bx;
        e0 = error;
        busy_lo = 0;
        for (int n = 0; n < budget; n++) begin
            if (busy !== 1'b1) busy_lo++;
            if (done === 1'b1) begin
                dn = n;
                er = error;
                break;
            end
            if (mode == 1) begin
                run         = (n == 20);
                core_wen    = (n == 25);
                core_addr   = 4'd0;
                core_result = 16'h1234;
            end
            @(negedge clk);
        end
        run      = 1'b0;
        core_wen = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        run   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        end
        checks++;
        if ({layer_start, matrix_valid, busy, done, error, matrix_result, rd_data} !== 37'd0) begin
            errors++;
            $display("FAIL reset_outputs: got ls=%b mv=%b busy=%b done=%b err=%b mr=%0h rd=%0h expected all 0",
                     layer_start, matrix_valid, busy, done, error, matrix_result, rd_data);
        end
        rst_n = 1'b1;
        run   = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
    endtask

    task automatic test_full_run();
        int dn, bl, ls0, mv0, h0, v0;
        logic er, e0;
        load(0);
        for (int i = 0; i < E; i++) begin
            exp_out[i] = res_a[i];
            exp_q.push_back(res_a[i]);
        end
        ls0 = ls_cnt; mv0 = mv_cnt; h0 = hold_bad; v0 = val_bad;
        do_run(200, 0, dn, er, e0, bl);
        checks++; if (dn != 54) begin errors++; $display("FAIL full_done_cycle: got %0d expected 54", dn); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL full_error: got %b expected 0", er); end
        checks++; if (bl != 0) begin errors++; $display("FAIL full_busy_span: got %0d low cycles expected 0", bl); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_fall: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL full_done_pulse: got %b expected 0", done); end
        checks++; if (ls_cnt - ls0 != E) begin errors++; $display("FAIL full_layer_start_cycles: got %0d expected %0d", ls_cnt - ls0, E); end
        checks++; if (mv_cnt - mv0 != E) begin errors++; $display("FAIL full_matrix_valid_cycles: got %0d expected %0d", mv_cnt - mv0, E); end
        checks++; if (hold_bad - h0 != 0) begin errors++; $display("FAIL full_hold: got %0d unstable cycles expected 0", hold_bad - h0); end
        checks++; if (val_bad - v0 != 0) begin errors++; $display("FAIL full_present_value: got %0d wrong elements expected 0", val_bad - v0); end
        readback(E);
    endtask

    task automatic test_timeout();
        int dn, bl;
        logic er, e0;
        no_resp = 1'b1;
        do_run(40, 0, dn, er, e0, bl);
        checks++; if (dn != 10) begin errors++; $display("FAIL timeout_done_cycle: got %0d expected 10", dn); end
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL timeout_error: got %b expected 1", er); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy_fall: got %b expected 0", busy); end
        repeat (3) @(negedge clk);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b expected 1", error); end
        no_resp = 1'b0;
        do_run(200, 0, dn, er, e0, bl);
        checks++; if (e0 !== 1'b0) begin errors++; $display("FAIL timeout_run_clears: got %b expected 0", e0); end
        checks++; if (dn != 54) begin errors++; $display("FAIL timeout_rerun_done: got %0d expected 54", dn); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL timeout_rerun_error: got %b expected 0", er); end
    endtask

    task automatic test_timeout_edge();
        int dn, bl;
        logic er, e0;
        lat = 8;
        do_run(200, 0, dn, er, e0, bl);
        checks++; if (dn != 90) begin errors++; $display("FAIL last_wait_done_cycle: got %0d expected 90", dn); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL last_wait_error: got %b expected 0", er); end
        lat = 9;
        do_run(40, 0, dn, er, e0, bl);
        checks++; if (dn != 10) begin errors++; $display("FAIL late_resp_done_cycle: got %0d expected 10", dn); end
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL late_resp_error: got %b expected 1", er); end
        lat = 4;
    endtask

    task automatic test_ignore();
        int dn, bl, ls0;
        logic er, e0;
        ls0 = ls_cnt;
        do_run(200, 1, dn, er, e0, bl);
        checks++; if (dn != 54) begin errors++; $display("FAIL ignore_done_cycle: got %0d expected 54", dn); end
        checks++; if (ls_cnt - ls0 != E) begin errors++; $display("FAIL ignore_layer_starts: got %0d expected %0d", ls_cnt - ls0, E); end
        @(negedge clk);
        force_res = 16'hBEEF;
        force_av  = 1'b1;
        repeat (3) @(negedge clk);
        force_av = 1'b0;
        for (int i = 0; i < E; i++) exp_q.push_back(exp_out[i]);
        readback(E);
        do_run(200, 0, dn, er, e0, bl);
        checks++; if (dn != 54) begin errors++; $display("FAIL ignore_rerun_done: got %0d expected 54", dn); end
        exp_q.push_back(res_a[0]);
        readback(1);
    endtask

    task automatic test_reset_mid();
        int dn, bl, dcount;
        logic er, e0;
        load(1);
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        repeat (26) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({layer_start, matrix_valid, busy, done, error, matrix_result, rd_data} !== 37'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got ls=%b mv=%b busy=%b done=%b err=%b mr=%0h rd=%0h expected all 0",
                     layer_start, matrix_valid, busy, done, error, matrix_result, rd_data);
        end
        dcount = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        checks++; if (dcount != 0) begin errors++; $display("FAIL midreset_no_done: got %0d pulses expected 0", dcount); end
        for (int i = 0; i < 4; i++) exp_out[i] = vec_b[i];
        for (int i = 0; i < E; i++) exp_q.push_back(exp_out[i]);
        readback(E);
        do_run(200, 0, dn, er, e0, bl);
        checks++; if (dn != 54) begin errors++; $display("FAIL midreset_rerun_done: got %0d expected 54", dn); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL midreset_rerun_error: got %b expected 0", er); end
        for (int i = 0; i < E; i++) begin
            exp_out[i] = vec_b[i];
            exp_q.push_back(vec_b[i]);
        end
        readback(E);
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_timeout();
        test_timeout_edge();
        test_ignore();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
